// File: rtl/gate_bist_ctrl_if.sv
// Bus between the gate-unit BIST sequencer and its surroundings: run control,
// the stimulus/response wires to the gate unit, and the result reporting.
// The sequencer takes the slave side; the system/test harness takes the master side.
interface gate_bist_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             start;      // run request, sampled only while idle
    logic             abort;      // cancel the current run
    logic             dut_a;      // gate unit input a
    logic             dut_b;      // gate unit input b
    logic [2:0]       dut_y;      // {y3,y2,y1} = {XOR, OR, NAND} from gate unit
    logic             busy;       // run in progress
    logic             done;       // one-cycle pulse at normal completion
    logic             pass;       // last completed run had zero mismatches
    logic [CNT_W-1:0] err_count;  // mismatching vectors, saturating
    logic [1:0]       fail_vec;   // {a,b} of first mismatching vector
    logic [2:0]       fail_bits;  // expected ^ observed at first mismatch

    modport master (
        output start, abort, dut_y,
        input  dut_a, dut_b, busy, done, pass, err_count, fail_vec, fail_bits
    );

    modport slave (
        input  start, abort, dut_y,
        output dut_a, dut_b, busy, done, pass, err_count, fail_vec, fail_bits
    );
endinterface

// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for the 2-input gate unit (y1=NAND, y2=OR, y3=XOR).
// Sweeps {a,b} through 0..3 for PASSES sweeps, holding each vector SETTLE_CYCLES
// cycles before a one-cycle sample, and records the mismatch count (saturating)
// plus the vector and failing output bits of the first mismatch of the run.
// All outputs come straight from flops; dut_y is only looked at in SAMPLE.
module gate_bist_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    gate_bist_ctrl_if.slave bif
);

    // Counter widths never drop below one bit so single-cycle / single-pass
    // configurations still elaborate cleanly.
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [1:0]          vec_q,       vec_d;
    logic [SET_W-1:0]    settle_q,    settle_d;
    logic [PASS_W-1:0]   pass_cnt_q,  pass_cnt_d;

    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                pass_q,      pass_d;
    logic                dut_a_q,     dut_a_d;
    logic                dut_b_q,     dut_b_d;
    logic [CNT_W-1:0]    err_q,       err_d;
    logic [1:0]          fail_vec_q,  fail_vec_d;
    logic [2:0]          fail_bits_q, fail_bits_d;

    logic [2:0]          expected;
    logic                mismatch;

    // Truth table of a healthy gate unit for input vector {a,b}: {XOR, OR, NAND}.
    function automatic logic [2:0] gate_expect(input logic [1:0] v);
        logic a;
        logic b;
        a = v[1];
        b = v[0];
        return {a ^ b, a | b, ~(a & b)};
    endfunction

    // Error counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Next-state, sweep counters, result bookkeeping and registered-output targets.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        settle_d    = settle_q;
        pass_cnt_d  = pass_cnt_q;
        err_d       = err_q;
        fail_vec_d  = fail_vec_q;
        fail_bits_d = fail_bits_q;
        pass_d      = pass_q;
        expected    = gate_expect(vec_q);
        mismatch    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Abort beats start when both arrive together in IDLE.
                if (bif.start && !bif.abort) begin
                    state_d     = S_APPLY;
                    vec_d       = 2'd0;
                    settle_d    = '0;
                    pass_cnt_d  = '0;
                    err_d       = '0;
                    fail_vec_d  = 2'd0;
                    fail_bits_d = 3'd0;
                    pass_d      = 1'b0;
                end
            end

            S_APPLY: begin
                if (settle_q == SET_LAST) begin
                    state_d  = S_SAMPLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end

            S_SAMPLE: begin
                mismatch = (bif.dut_y != expected);
                if (mismatch) begin
                    err_d = sat_inc(err_q);
                    // A saturating count never returns to zero inside a run, so a
                    // zero count means this is the first mismatch.
                    if (err_q == '0) begin
                        fail_vec_d  = vec_q;
                        fail_bits_d = expected ^ bif.dut_y;
                    end
                end
                if ((vec_q == 2'd3) && (pass_cnt_q == PASS_LAST)) begin
                    state_d = S_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = S_APPLY;
                    vec_d   = vec_q + 2'd1;
                    if (vec_q == 2'd3) begin
                        pass_cnt_d = pass_cnt_q + PASS_W'(1);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort outranks everything outside IDLE; partial error info is kept,
        // the sample taken this cycle is discarded and no done pulse follows.
        if (bif.abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            vec_d       = 2'd0;
            settle_d    = '0;
            pass_cnt_d  = '0;
            err_d       = err_q;
            fail_vec_d  = fail_vec_q;
            fail_bits_d = fail_bits_q;
            pass_d      = 1'b0;
        end

        busy_d  = (state_d == S_APPLY) || (state_d == S_SAMPLE);
        done_d  = (state_d == S_DONE);
        dut_a_d = busy_d & vec_d[1];
        dut_b_d = busy_d & vec_d[0];
    end

    // FSM state and sweep position (vector, settle count, pass count).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            vec_q      <= 2'd0;
            settle_q   <= '0;
            pass_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            settle_q   <= settle_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    // Registered outputs: stimulus, status flags and run results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            dut_a_q     <= 1'b0;
            dut_b_q     <= 1'b0;
            err_q       <= '0;
            fail_vec_q  <= 2'd0;
            fail_bits_q <= 3'd0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            dut_a_q     <= dut_a_d;
            dut_b_q     <= dut_b_d;
            err_q       <= err_d;
            fail_vec_q  <= fail_vec_d;
            fail_bits_q <= fail_bits_d;
        end
    end

    assign bif.busy      = busy_q;
    assign bif.done      = done_q;
    assign bif.pass      = pass_q;
    assign bif.dut_a     = dut_a_q;
    assign bif.dut_b     = dut_b_q;
    assign bif.err_count = err_q;
    assign bif.fail_vec  = fail_vec_q;
    assign bif.fail_bits = fail_bits_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: three sequencers with different settle/pass/count
// configurations, each wired to a behavioural gate unit with a per-vector fault
// mask on its outputs. Results are predicted from the fault masks alone.
module tb_gate_bist_ctrl;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance configurations: k0 defaults, k1 eight passes, k2 long settle / narrow count.
    function automatic int p_settle(input int k);
        return (k == 2) ? 3 : 1;
    endfunction
    function automatic int p_passes(input int k);
        return (k == 1) ? 8 : 1;
    endfunction
    function automatic int p_cntw(input int k);
        return (k == 2) ? 2 : 4;
    endfunction

    gate_bist_ctrl_if #(.CNT_W(4)) if0 ();
    gate_bist_ctrl_if #(.CNT_W(4)) if1 ();
    gate_bist_ctrl_if #(.CNT_W(2)) if2 ();

    gate_bist_ctrl #(.SETTLE_CYCLES(1), .PASSES(1), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bif(if0.slave));
    gate_bist_ctrl #(.SETTLE_CYCLES(1), .PASSES(8), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bif(if1.slave));
    gate_bist_ctrl #(.SETTLE_CYCLES(3), .PASSES(1), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bif(if2.slave));

    logic       start_v [3];
    logic       abort_v [3];
    logic [2:0] fmask   [3][4];   // XOR'd onto the gate outputs per {a,b}

    logic       busy_v [3];
    logic       done_v [3];
    logic       pass_v [3];
    logic       a_v    [3];
    logic       b_v    [3];
    logic [3:0] err_v  [3];
    logic [1:0] fv_v   [3];
    logic [2:0] fb_v   [3];

    // Healthy gate unit: y1=NAND, y2=OR, y3=XOR.
    function automatic logic [2:0] gate_ok(input logic a, input logic b);
        return {a ^ b, a | b, ~(a & b)};
    endfunction

    assign if0.start = start_v[0];
    assign if1.start = start_v[1];
    assign if2.start = start_v[2];
    assign if0.abort = abort_v[0];
    assign if1.abort = abort_v[1];
    assign if2.abort = abort_v[2];
    assign if0.dut_y = gate_ok(if0.dut_a, if0.dut_b) ^ fmask[0][{if0.dut_a, if0.dut_b}];
    assign if1.dut_y = gate_ok(if1.dut_a, if1.dut_b) ^ fmask[1][{if1.dut_a, if1.dut_b}];
    assign if2.dut_y = gate_ok(if2.dut_a, if2.dut_b) ^ fmask[2][{if2.dut_a, if2.dut_b}];

    assign busy_v[0] = if0.busy;      assign busy_v[1] = if1.busy;      assign busy_v[2] = if2.busy;
    assign done_v[0] = if0.done;      assign done_v[1] = if1.done;      assign done_v[2] = if2.done;
    assign pass_v[0] = if0.pass;      assign pass_v[1] = if1.pass;      assign pass_v[2] = if2.pass;
    assign a_v[0]    = if0.dut_a;     assign a_v[1]    = if1.dut_a;     assign a_v[2]    = if2.dut_a;
    assign b_v[0]    = if0.dut_b;     assign b_v[1]    = if1.dut_b;     assign b_v[2]    = if2.dut_b;
    assign err_v[0]  = if0.err_count; assign err_v[1]  = if1.err_count; assign err_v[2]  = {2'b00, if2.err_count};
    assign fv_v[0]   = if0.fail_vec;  assign fv_v[1]   = if1.fail_vec;  assign fv_v[2]   = if2.fail_vec;
    assign fb_v[0]   = if0.fail_bits; assign fb_v[1]   = if1.fail_bits; assign fb_v[2]   = if2.fail_bits;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the sweeps; a vector mismatches whenever its fault mask is
    // non-zero, the count saturates at 2**CNT_W-1, the first mismatch is latched.
    task automatic ref_run(input int k, output int ecnt, output int fv, output int fb);
        int cmax;
        cmax = (1 << p_cntw(k)) - 1;
        ecnt = 0;
        fv   = 0;
        fb   = 0;
        for (int p = 0; p < p_passes(k); p++) begin
            for (int v = 0; v < 4; v++) begin
                if (fmask[k][v] != 3'b000) begin
                    if (ecnt == 0) begin
                        fv = v;
                        fb = int'(fmask[k][v]);
                    end
                    if (ecnt < cmax) ecnt++;
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag, input int k);
        check_val({tag, " busy"},  busy_v[k], 0);
        check_val({tag, " done"},  done_v[k], 0);
        check_val({tag, " dut_a"}, a_v[k],    0);
        check_val({tag, " dut_b"}, b_v[k],    0);
    endtask

    // One full run on instance k from IDLE; optionally re-pulses start while busy
    // and in DONE, which must neither restart nor queue a run.
    task automatic run_check(input int k, input bit repulse);
        int lat;
        int ecnt;
        int fv;
        int fb;
        int vexp;
        lat = p_passes(k) * 4 * (p_settle(k) + 1);
        ref_run(k, ecnt, fv, fb);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            vexp = ((c - 1) / (p_settle(k) + 1)) % 4;
            check_val($sformatf("k%0d busy c%0d", k, c), busy_v[k], 1);
            check_val($sformatf("k%0d vec c%0d", k, c), {a_v[k], b_v[k]}, vexp);
            check_val($sformatf("k%0d done c%0d", k, c), done_v[k], 0);
            if (c == 1) begin
                check_val($sformatf("k%0d err clr", k), err_v[k], 0);
                check_val($sformatf("k%0d pass clr", k), pass_v[k], 0);
                check_val($sformatf("k%0d fvec clr", k), fv_v[k], 0);
                check_val($sformatf("k%0d fbits clr", k), fb_v[k], 0);
            end
            start_v[k] = repulse ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        check_val($sformatf("k%0d done", k), done_v[k], 1);
        check_val($sformatf("k%0d busy@done", k), busy_v[k], 0);
        check_val($sformatf("k%0d ab@done", k), {a_v[k], b_v[k]}, 0);
        check_val($sformatf("k%0d pass", k), pass_v[k], (ecnt == 0) ? 1 : 0);
        check_val($sformatf("k%0d err_count", k), err_v[k], ecnt);
        check_val($sformatf("k%0d fail_vec", k), fv_v[k], fv);
        check_val($sformatf("k%0d fail_bits", k), fb_v[k], fb);
        start_v[k] = repulse;
        @(negedge clk);
        start_v[k] = 1'b0;
        check_idle_outputs($sformatf("k%0d post1", k), k);
        @(negedge clk);
        check_idle_outputs($sformatf("k%0d post2", k), k);
        check_val($sformatf("k%0d pass hold", k), pass_v[k], (ecnt == 0) ? 1 : 0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            abort_v[k] = 1'b0;
            for (int v = 0; v < 4; v++) fmask[k][v] = 3'b000;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_idle_outputs($sformatf("k%0d rst", k), k);
            check_val($sformatf("k%0d rst pass", k), pass_v[k], 0);
            check_val($sformatf("k%0d rst err", k), err_v[k], 0);
            check_val($sformatf("k%0d rst fvec", k), fv_v[k], 0);
            check_val($sformatf("k%0d rst fbits", k), fb_v[k], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Healthy unit, default configuration.
        run_check(0, 1'b0);

        // Abort alone and abort together with start, both in IDLE: no effect.
        abort_v[0] = 1'b1;
        @(negedge clk);
        check_val("idle abort pass", pass_v[0], 1);
        check_val("idle abort busy", busy_v[0], 0);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        check_val("start+abort busy", busy_v[0], 0);
        check_val("start+abort pass", pass_v[0], 1);
        @(negedge clk);
        check_val("start+abort later", busy_v[0], 0);

        // y3 stuck-at-0: fails only where a^b=1, i.e. vectors 01 and 10.
        fmask[0][1] = 3'b100;
        fmask[0][2] = 3'b100;
        run_check(0, 1'b1);

        // y1 inverted over eight passes: 32 mismatches saturate the 4-bit count.
        for (int v = 0; v < 4; v++) fmask[1][v] = 3'b001;
        run_check(1, 1'b0);

        // Long settle: 16-cycle run on a healthy unit.
        run_check(2, 1'b0);

        // Abort during the second SAMPLE after a mismatch on vector 0.
        fmask[0][0] = 3'b001;
        fmask[0][1] = 3'b000;
        fmask[0][2] = 3'b000;
        fmask[0][3] = 3'b000;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        check_val("abort pre busy", busy_v[0], 1);
        check_val("abort pre vec", {a_v[0], b_v[0]}, 1);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        check_idle_outputs("abort", 0);
        check_val("abort pass", pass_v[0], 0);
        check_val("abort err", err_v[0], 1);
        check_val("abort fvec", fv_v[0], 0);
        check_val("abort fbits", fb_v[0], 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_val($sformatf("abort no done %0d", c), done_v[0], 0);
        end
        fmask[0][0] = 3'b000;
        run_check(0, 1'b0);

        // Asynchronous reset in the middle of APPLY for vector 2.
        for (int v = 0; v < 4; v++) fmask[0][v] = 3'b001;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check_val("prerst busy", busy_v[0], 1);
        check_val("prerst err", err_v[0], 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async rst", 0);
        check_val("async rst pass", pass_v[0], 0);
        check_val("async rst err", err_v[0], 0);
        check_val("async rst fvec", fv_v[0], 0);
        check_val("async rst fbits", fb_v[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_idle_outputs($sformatf("after rst %0d", c), 0);
        end
        run_check(0, 1'b1);

        // Randomised fault patterns across all three configurations.
        for (int it = 0; it < 12; it++) begin
            int k;
            k = $urandom_range(0, 2);
            for (int v = 0; v < 4; v++) begin
                fmask[k][v] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
            end
            run_check(k, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
